// File: rtl/display_scheduler_if.sv
// Requester/display bundle for display_scheduler.
// master = requester/display side, slave = the scheduler itself.
interface display_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   ReqValid;
    logic [8*NUM_REQ-1:0] ReqValue;
    logic                 Hold;
    logic                 Next;
    logic [7:0]           DisplayValue;
    logic                 DisplayValid;
    logic [IW-1:0]        SourceIndex;
    logic [NUM_REQ-1:0]   Grant;
    logic                 SlotDone;

    modport master (
        output ReqValid, ReqValue, Hold, Next,
        input  DisplayValue, DisplayValid, SourceIndex, Grant, SlotDone
    );

    modport slave (
        input  ReqValid, ReqValue, Hold, Next,
        output DisplayValue, DisplayValid, SourceIndex, Grant, SlotDone
    );
endinterface

// File: rtl/display_scheduler.sv
// Round-robin time-sharing of one 8-bit seven-segment display among
// NUM_REQ requesters, with a dwell period per source and a blank gap
// whenever the shown source changes. All outputs are registered.
module display_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DWELL   = 50_000_000,
    parameter int BLANK   = 5_000_000
) (
    input  logic               Clock,
    input  logic               Reset,
    display_scheduler_if.slave bus
);
    localparam int IW   = $clog2(NUM_REQ);
    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(MAXC);

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_BLANK} state_t;

    state_t          state;
    logic [IW-1:0]   cur;
    logic [CW-1:0]   dwell_cnt;
    logic [CW-1:0]   blank_cnt;

    logic            nxt_found;
    logic [IW-1:0]   nxt_idx;
    logic [IW-1:0]   probe;
    int              pos;
    logic [7:0]      cur_val;
    logic [7:0]      nxt_val;
    logic            cur_valid;
    logic            slot_end;

    // Round-robin search: first valid requester after cur, cur itself last.
    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = cur;
        pos       = 0;
        probe     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = int'(cur) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            probe = IW'(pos);
            if (!nxt_found && bus.ReqValid[probe]) begin
                nxt_found = 1'b1;
                nxt_idx   = probe;
            end
        end
    end

    // Current/next source data and the combined slot-end condition; Next
    // and a dropped request both override Hold.
    always_comb begin
        cur_val   = bus.ReqValue[8*int'(cur) +: 8];
        nxt_val   = bus.ReqValue[8*int'(nxt_idx) +: 8];
        cur_valid = bus.ReqValid[cur];
        slot_end  = bus.Next || !cur_valid ||
                    ((dwell_cnt == CW'(DWELL-1)) && !bus.Hold);
    end

    // Scheduler FSM with registered display outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state            <= S_IDLE;
            cur              <= IW'(NUM_REQ-1);
            dwell_cnt        <= '0;
            blank_cnt        <= '0;
            bus.DisplayValue <= '0;
            bus.DisplayValid <= 1'b0;
            bus.SourceIndex  <= '0;
            bus.Grant        <= '0;
            bus.SlotDone     <= 1'b0;
        end else begin
            bus.SlotDone <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (nxt_found) begin
                        state            <= S_SHOW;
                        cur              <= nxt_idx;
                        dwell_cnt        <= '0;
                        bus.DisplayValue <= nxt_val;
                        bus.DisplayValid <= 1'b1;
                        bus.SourceIndex  <= nxt_idx;
                        bus.Grant        <= {{(NUM_REQ-1){1'b0}}, 1'b1} << nxt_idx;
                    end else begin
                        bus.DisplayValue <= '0;
                        bus.DisplayValid <= 1'b0;
                        bus.SourceIndex  <= '0;
                        bus.Grant        <= '0;
                    end
                end
                S_SHOW: begin
                    if (slot_end) begin
                        bus.SlotDone <= 1'b1;
                        if (!nxt_found) begin
                            state            <= S_IDLE;
                            bus.DisplayValue <= '0;
                            bus.DisplayValid <= 1'b0;
                            bus.SourceIndex  <= '0;
                            bus.Grant        <= '0;
                        end else if (nxt_idx == cur) begin
                            // Sole requester: restart its slot without a gap.
                            dwell_cnt        <= '0;
                            bus.DisplayValue <= cur_val;
                        end else begin
                            // SourceIndex deliberately keeps the old source.
                            state            <= S_BLANK;
                            blank_cnt        <= '0;
                            bus.DisplayValue <= '0;
                            bus.DisplayValid <= 1'b0;
                            bus.Grant        <= '0;
                        end
                    end else begin
                        if (!bus.Hold) dwell_cnt <= dwell_cnt + 1'b1;
                        bus.DisplayValue <= cur_val;
                    end
                end
                S_BLANK: begin
                    if (blank_cnt == CW'(BLANK-1)) begin
                        if (nxt_found) begin
                            state            <= S_SHOW;
                            cur              <= nxt_idx;
                            dwell_cnt        <= '0;
                            bus.DisplayValue <= nxt_val;
                            bus.DisplayValid <= 1'b1;
                            bus.SourceIndex  <= nxt_idx;
                            bus.Grant        <= {{(NUM_REQ-1){1'b0}}, 1'b1} << nxt_idx;
                        end else begin
                            state           <= S_IDLE;
                            bus.SourceIndex <= '0;
                        end
                    end else begin
                        blank_cnt <= blank_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler (NUM_REQ=4, DWELL=4, BLANK=2): directed
// scenarios followed by random traffic, compared every cycle against a
// slot-level model that tracks remaining cycles per slot.
module tb_display_scheduler;
    localparam int N     = 4;
    localparam int DWELL = 4;
    localparam int BLANK = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rv;
    logic [7:0] vals [N];
    logic       hold;
    logic       nxt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state: mode 0 idle, 1 showing, 2 blanking.
    int         m_mode;
    int         m_cur;
    int         m_left;
    logic [7:0] e_val;
    logic       e_valid;
    int         e_idx;
    logic [3:0] e_grant;
    logic       e_done;

    display_scheduler_if #(.NUM_REQ(N)) bus ();

    display_scheduler #(.NUM_REQ(N), .DWELL(DWELL), .BLANK(BLANK)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    assign bus.ReqValid = rv;
    assign bus.ReqValue = {vals[3], vals[2], vals[1], vals[0]};
    assign bus.Hold     = hold;
    assign bus.Next     = nxt;

    always #5 clk = ~clk;

    function automatic int search(int c, logic [3:0] v);
        for (int k = 1; k <= N; k++)
            if (v[(c + k) % N]) return (c + k) % N;
        return -1;
    endfunction

    task automatic show_src(int j);
        m_mode  = 1;
        m_cur   = j;
        m_left  = DWELL;
        e_val   = vals[j];
        e_valid = 1'b1;
        e_idx   = j;
        e_grant = 4'(1 << j);
    endtask

    task automatic go_idle();
        m_mode  = 0;
        e_val   = 8'h00;
        e_valid = 1'b0;
        e_idx   = 0;
        e_grant = 4'b0000;
    endtask

    task automatic model_edge();
        int j;
        e_done = 1'b0;
        j = search(m_cur, rv);
        if (rst) begin
            go_idle();
            m_cur = N - 1;
        end else if (m_mode == 0) begin
            if (j >= 0) show_src(j);
        end else if (m_mode == 1) begin
            if (nxt || !rv[m_cur] || (!hold && m_left == 1)) begin
                e_done = 1'b1;
                if (j < 0) go_idle();
                else if (j == m_cur) show_src(j);
                else begin
                    m_mode  = 2;
                    m_left  = BLANK;
                    e_val   = 8'h00;
                    e_valid = 1'b0;
                    e_grant = 4'b0000;
                end
            end else begin
                if (!hold) m_left--;
                e_val = vals[m_cur];
            end
        end else begin
            if (m_left == 1) begin
                if (j < 0) go_idle();
                else show_src(j);
            end else m_left--;
        end
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock: model follows the same sampled inputs, outputs checked 1ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("DisplayValue", 32'(bus.DisplayValue), 32'(e_val));
        chk("DisplayValid", 32'(bus.DisplayValid), 32'(e_valid));
        chk("SourceIndex",  32'(bus.SourceIndex),  32'(e_idx));
        chk("Grant",        32'(bus.Grant),        32'(e_grant));
        chk("SlotDone",     32'(bus.SlotDone),     32'(e_done));
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the model enters the first cycle of source `src`.
    task automatic wait_show(int src);
        int n = 0;
        while (!(m_mode == 1 && m_cur == src && m_left == DWELL && e_done == 1'b0 || 
                 m_mode == 1 && m_cur == src && m_left == DWELL && n > 0 && e_valid) && n < 40) begin
            step();
            n++;
        end
        chk("wait_show_reached", 32'(n < 40), 32'd1);
    endtask

    initial begin
        rst  = 1'b1;
        rv   = 4'b0000;
        hold = 1'b0;
        nxt  = 1'b0;
        for (int i = 0; i < N; i++) vals[i] = 8'h00;
        m_cur = N - 1;
        go_idle();
        e_done = 1'b0;
        m_left = 0;

        // Reset and idle with no requesters.
        steps(2);
        #1 rst = 1'b0;
        steps(10);

        // Single requester: shown forever, SlotDone every DWELL, never blanks.
        vals[0] = 8'hA5;
        rv = 4'b0001;
        steps(20);

        // Three requesters, index 2 skipped.
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        rv = 4'b1011;
        steps(24);

        // Hold on source 1 for 20 cycles, then release.
        wait_show(1);
        hold = 1'b1;
        steps(20);
        hold = 1'b0;
        steps(8);

        // Next on the 2nd cycle of source 0 with Hold set; Next during blank.
        wait_show(0);
        hold = 1'b1;
        step();
        nxt = 1'b1;
        step();
        nxt = 1'b0;
        chk("next_slotdone", 32'(bus.SlotDone), 32'd1);
        nxt = 1'b1;
        step();
        nxt = 1'b0;
        step();
        chk("after_next_src", 32'(bus.SourceIndex), 32'd1);
        hold = 1'b0;
        steps(3);

        // Drop the current requester mid-slot, then drop everyone.
        wait_show(3);
        step();
        rv = 4'b0011;
        steps(4);
        rv = 4'b0000;
        steps(8);
        chk("idle_valid", 32'(bus.DisplayValid), 32'd0);

        // Reset in the middle of showing source 3.
        rv = 4'b1000;
        vals[3] = 8'h5C;
        wait_show(3);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("post_reset_src3", 32'(bus.Grant), 32'b1000);
        steps(3);

        // Random traffic with live value changes, holds, nexts and resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) vals[i] = 8'($urandom);
            if ($urandom_range(0, 7) == 0) rv = 4'($urandom);
            if ($urandom_range(0, 9) == 0) hold = ~hold;
            nxt = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst  = 1'b0;
        nxt  = 1'b0;
        hold = 1'b0;
        steps(4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/display_scheduler.md
# display_scheduler

Round-robin scheduler sharing the single 8-bit binary seven-segment display among up to NUM_REQ requesters (CPU registers, ALU result, PC, bus value). Rotates the display between active requesters with a programmable dwell and blanking gap, supports freeze and manual advance, and drives DisplayValue of the seven-segment decoder directly.

## Interface

Parameters:
- NUM_REQ, 4: number of requesters (2..8)
- DWELL, 50_000_000: cycles each requester is shown (≥2)
- BLANK, 5_000_000: blank cycles between different sources (≥1)

Ports:
- Clock  input  1  single clock, all state on rising edge
- Reset  input  1  synchronous, active-high; dominates all inputs
- ReqValid  input  NUM_REQ  bit i high = requester i wants display time
- ReqValue  input  8*NUM_REQ  requester i value in bits [8i+7:8i]
- Hold  input  1  freeze rotation on current source (level)
- Next  input  1  single-cycle pulse: force advance
- DisplayValue  output  8  value to seven-segment decoder (registered)
- DisplayValid  output  1  high while a source is shown
- SourceIndex  output  $clog2(NUM_REQ)  index of shown source
- Grant  output  NUM_REQ  one-hot of shown source, 0 otherwise
- SlotDone  output  1  one-cycle pulse when a slot ends

## Operation

- States: IDLE, SHOW, BLANK. Registers: state, cur, dwell counter, blank counter.
- Round-robin search: first i with ReqValid[i]=1 starting at cur+1, wrapping modulo NUM_REQ, cur itself checked last.
- IDLE: outputs zero. Any ReqValid high → SHOW with cur = search result, dwell counter = 0.
- SHOW: each edge DisplayValue ← ReqValue[cur] (live tracking); dwell counter increments unless Hold=1.
- Slot end in SHOW when any of: counter == DWELL-1 and Hold=0; Next=1 (overrides Hold); ReqValid[cur]=0 (overrides Hold). SlotDone pulses on the transition edge.
- On slot end: search result j. If j == cur (only cur valid) → stay SHOW, counter = 0, no blank. If j ≠ cur → BLANK. If no requester valid → IDLE.
- BLANK: DisplayValid=0, DisplayValue=0, Grant=0, SourceIndex keeps old cur. After BLANK cycles, search re-evaluated: result → SHOW with new cur; none valid → IDLE. Next and Hold ignored in BLANK.
- Simultaneous slot-end conditions produce exactly one advance and one SlotDone pulse.

## Timing

- Reset (edge with Reset=1): state IDLE, cur = NUM_REQ-1 (first search starts at 0), counters 0, DisplayValue=0, DisplayValid=0, SourceIndex=0, Grant=0, SlotDone=0.
- Reset mid-SHOW or mid-BLANK: all of the above on the next edge, no SlotDone.
- Latency: ReqValid/ReqValue sampled at edge k → DisplayValue, DisplayValid, Grant, SourceIndex valid after edge k (1-cycle registered path); same for ReqValue changes in SHOW.
- Uninterrupted slot length: exactly DWELL cycles with DisplayValid=1, then exactly BLANK cycles with DisplayValid=0.
- Next sampled high in SHOW: DisplayValid drops (or source restarts) on the following edge.
- Grant, SourceIndex, DisplayValid change on the same edge; Grant is always onehot0 and equals 1<<SourceIndex when DisplayValid=1.
- Counter width $clog2(max(DWELL,BLANK)); no wrap beyond terminal count.

## Test plan

(DWELL=4, BLANK=2, NUM_REQ=4)
- Reset, ReqValid=4'b0000 → DisplayValid=0, DisplayValue=0, Grant=0 for 10 cycles; then ReqValid=4'b0001, ReqValue[7:0]=8'hA5 → next edge DisplayValid=1, SourceIndex=0, DisplayValue=8'hA5, stays 8'hA5 indefinitely with SlotDone every 4 cycles, never blanks.
- ReqValid=4'b1011, values 8'h11/8'h22/—/8'h44 → sequence 11×4, blank×2, 22×4, blank×2, 44×4, blank×2, 11 (index 2 skipped).
- Hold=1 during source 1 for 20 cycles → DisplayValue=8'h22 throughout, no SlotDone; release → slot ends after the remaining dwell cycles.
- Next pulse on 2nd cycle of source 0 with Hold=1 → SlotDone next edge, 2 blank cycles, source 1 shown; Next during BLANK has no effect.
- Drop ReqValid[cur] mid-slot with others valid → SlotDone, blank, next valid source; drop all ReqValid → IDLE, outputs 0.
- Assert Reset mid-SHOW of source 3 → next edge all outputs 0; after release with ReqValid=4'b1000 source 3 shown after one edge.
